cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetches an 8-bit opcode, steers one bus driver and one
// capture enable per instruction, and handles program loading, stepping and halt.
module cpu_sequencer #(
    parameter logic [7:0] HALT_OP = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step_mode,
    input  logic       step_req,
    input  logic       load_req,
    input  logic       load_done,
    input  logic [7:0] ram_data,
    input  logic       branch_taken,
    output logic       ram_grant_ext,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [7:0] ir,
    output logic [7:0] src_load_en,
    output logic [7:0] dst_save_en,
    output logic       imm_en,
    output logic       alu_en,
    output logic       busy,
    output logic [2:0] state,
    output logic [7:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FETCH  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_WRITE  = 3'd5,
        S_PAUSE  = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [1:0] CLS_IMM    = 2'b00;
    localparam logic [1:0] CLS_ALU    = 2'b01;
    localparam logic [1:0] CLS_COPY   = 2'b10;
    localparam logic [1:0] CLS_BRANCH = 2'b11;

    state_t     state_q;
    logic [7:0] ir_q;
    logic [7:0] count_q;
    logic       imm_en_q;
    logic       alu_en_q;
    logic [7:0] src_q;
    logic [7:0] dst_q;
    logic       pc_inc_wr_q;
    logic       grant_q;
    logic       exec_branch;
    state_t     retire_next;

    // Where to go once an instruction retires; step_mode wins over run.
    always_comb begin
        retire_next = S_IDLE;
        if (step_mode)
            retire_next = S_PAUSE;
        else if (run)
            retire_next = S_FETCH;
    end

    // Loader handshake: load_req is a level sampled only in IDLE; the grant is
    // held for the whole of LOAD and released by a load_done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ir_q        <= 8'h00;
            count_q     <= 8'h00;
            imm_en_q    <= 1'b0;
            alu_en_q    <= 1'b0;
            src_q       <= 8'h00;
            dst_q       <= 8'h00;
            pc_inc_wr_q <= 1'b0;
            grant_q     <= 1'b0;
        end else begin
            imm_en_q    <= 1'b0;
            alu_en_q    <= 1'b0;
            src_q       <= 8'h00;
            dst_q       <= 8'h00;
            pc_inc_wr_q <= 1'b0;
            grant_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_req) begin
                        state_q <= S_LOAD;
                        grant_q <= 1'b1;
                    end else if (run) begin
                        state_q <= S_FETCH;
                    end
                end
                S_LOAD: begin
                    if (load_done)
                        state_q <= S_IDLE;
                    else
                        grant_q <= 1'b1;
                end
                S_FETCH: begin
                    ir_q    <= ram_data;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    // Halt is checked first: the default HALT_OP sits in the branch class.
                    if (ir_q == HALT_OP) begin
                        state_q <= S_HALT;
                    end else begin
                        state_q <= S_EXEC;
                        case (ir_q[7:6])
                            CLS_IMM:  imm_en_q <= 1'b1;
                            CLS_ALU:  alu_en_q <= 1'b1;
                            CLS_COPY: src_q    <= 8'h01 << ir_q[5:3];
                            default:  ;
                        endcase
                    end
                end
                S_EXEC: begin
                    if (ir_q[7:6] == CLS_BRANCH) begin
                        count_q <= count_q + 8'd1;
                        state_q <= retire_next;
                    end else begin
                        state_q     <= S_WRITE;
                        pc_inc_wr_q <= 1'b1;
                        case (ir_q[7:6])
                            CLS_IMM:  dst_q <= 8'h01;
                            CLS_ALU:  dst_q <= 8'h08;
                            default:  dst_q <= 8'h01 << ir_q[2:0];
                        endcase
                    end
                end
                S_WRITE: begin
                    count_q <= count_q + 8'd1;
                    state_q <= retire_next;
                end
                S_PAUSE: begin
                    if (!run)
                        state_q <= S_IDLE;
                    else if (step_req)
                        state_q <= S_FETCH;
                end
                S_HALT: begin
                    if (!run)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Branch strobes follow branch_taken live, since it is only valid during EXEC.
    assign exec_branch = (state_q == S_EXEC) && (ir_q[7:6] == CLS_BRANCH);
    assign pc_load     = exec_branch && branch_taken;
    assign pc_inc      = pc_inc_wr_q || (exec_branch && !branch_taken);

    assign ram_grant_ext = grant_q;
    assign ir            = ir_q;
    assign src_load_en   = src_q;
    assign dst_save_en   = dst_q;
    assign imm_en        = imm_en_q;
    assign alu_en        = alu_en_q;
    assign busy          = (state_q != S_IDLE) && (state_q != S_HALT);
    assign state         = state_q;
    assign instr_count   = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: walks each instruction class, loader,
// stepping, halt, asynchronous reset and the retirement counter wrap.
module tb_cpu_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic       step_mode;
    logic       step_req;
    logic       load_req;
    logic       load_done;
    logic [7:0] ram_data;
    logic       branch_taken;
    logic       ram_grant_ext;
    logic       pc_inc;
    logic       pc_load;
    logic [7:0] ir;
    logic [7:0] src_load_en;
    logic [7:0] dst_save_en;
    logic       imm_en;
    logic       alu_en;
    logic       busy;
    logic [2:0] state;
    logic [7:0] instr_count;

    int checks = 0;
    int errors = 0;
    int lat;

    // {pc_inc, pc_load, imm_en, alu_en, src_load_en, dst_save_en}
    logic [19:0] strb;
    assign strb = {pc_inc, pc_load, imm_en, alu_en, src_load_en, dst_save_en};

    cpu_sequencer #(.HALT_OP(8'hFF)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .step_mode    (step_mode),
        .step_req     (step_req),
        .load_req     (load_req),
        .load_done    (load_done),
        .ram_data     (ram_data),
        .branch_taken (branch_taken),
        .ram_grant_ext(ram_grant_ext),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .ir           (ir),
        .src_load_en  (src_load_en),
        .dst_save_en  (dst_save_en),
        .imm_en       (imm_en),
        .alu_en       (alu_en),
        .busy         (busy),
        .state        (state),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles_to_fetch(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (state != 3'd2 && n < 20);
    endtask

    initial begin
        rst = 1'b0; run = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        load_req = 1'b0; load_done = 1'b0; ram_data = 8'h00; branch_taken = 1'b0;

        #3;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ir", 32'(ir), 32'h00);
        check("rst_count", 32'(instr_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(ram_grant_ext), 32'd0);
        check("rst_strobes", 32'(strb), 32'h00000);
        tick(); tick();
        rst = 1'b1;
        check("idle_after_rst", 32'(state), 32'd0);

        // immediate 0x05
        run = 1'b1; ram_data = 8'h05;
        tick(); check("imm_fetch", 32'(state), 32'd2); check("imm_fetch_busy", 32'(busy), 32'd1);
        check("imm_fetch_strb", 32'(strb), 32'h00000);
        tick(); check("imm_decode", 32'(state), 32'd3); check("imm_ir", 32'(ir), 32'h05);
        tick(); check("imm_exec", 32'(state), 32'd4); check("imm_exec_strb", 32'(strb), 32'h20000);
        tick(); check("imm_write", 32'(state), 32'd5); check("imm_write_strb", 32'(strb), 32'h80001);
        check("imm_cnt_pre", 32'(instr_count), 32'd0);
        tick(); check("imm_next_fetch", 32'(state), 32'd2); check("imm_count", 32'(instr_count), 32'd1);
        check("imm_after_strb", 32'(strb), 32'h00000);

        // copy r1 -> r3
        ram_data = 8'h8B;
        tick(); check("cp_ir", 32'(ir), 32'h8B);
        tick(); check("cp_exec_strb", 32'(strb), 32'h00200);
        tick(); check("cp_write_strb", 32'(strb), 32'h80008);
        tick(); check("cp_fetch", 32'(state), 32'd2); check("cp_count", 32'(instr_count), 32'd2);

        // branch taken then not taken
        ram_data = 8'hC1; branch_taken = 1'b1;
        tick(); check("br_decode", 32'(state), 32'd3);
        tick(); check("br_t_exec", 32'(state), 32'd4); check("br_t_strb", 32'(strb), 32'h40000);
        tick(); check("br_t_fetch", 32'(state), 32'd2); check("br_t_count", 32'(instr_count), 32'd3);
        check("br_t_after", 32'(strb), 32'h00000);
        branch_taken = 1'b0;
        tick(); tick(); check("br_n_strb", 32'(strb), 32'h80000);
        tick(); check("br_n_fetch", 32'(state), 32'd2); check("br_n_count", 32'(instr_count), 32'd4);

        // ALU 0x40
        ram_data = 8'h40;
        tick(); tick(); check("alu_exec_strb", 32'(strb), 32'h10000);
        tick(); check("alu_write_strb", 32'(strb), 32'h80008);
        tick(); check("alu_count", 32'(instr_count), 32'd5);

        // latency measured FETCH to FETCH
        ram_data = 8'h05;
        cycles_to_fetch(lat); check("lat_imm", 32'(lat), 32'd4); check("lat_imm_cnt", 32'(instr_count), 32'd6);
        ram_data = 8'hC1; branch_taken = 1'b0;
        cycles_to_fetch(lat); check("lat_br", 32'(lat), 32'd3); check("lat_br_cnt", 32'(instr_count), 32'd7);

        // run dropped mid-instruction still completes it
        ram_data = 8'h05; run = 1'b0;
        tick(); tick(); tick(); check("drop_write", 32'(state), 32'd5);
        tick(); check("drop_idle", 32'(state), 32'd0); check("drop_count", 32'(instr_count), 32'd8);
        tick(); check("drop_stay", 32'(state), 32'd0);

        // loader wins over run
        load_req = 1'b1; run = 1'b1;
        tick(); check("ld_state", 32'(state), 32'd1); check("ld_grant", 32'(ram_grant_ext), 32'd1);
        check("ld_busy", 32'(busy), 32'd1);
        load_req = 1'b0;
        tick(); check("ld_hold", 32'(ram_grant_ext), 32'd1); check("ld_hold_state", 32'(state), 32'd1);
        load_done = 1'b1;
        tick(); load_done = 1'b0;
        check("ld_idle", 32'(state), 32'd0); check("ld_release", 32'(ram_grant_ext), 32'd0);
        tick(); check("ld_fetch", 32'(state), 32'd2);

        // single stepping
        step_mode = 1'b1;
        tick(); tick(); tick(); tick();
        check("step_pause", 32'(state), 32'd6); check("step_cnt1", 32'(instr_count), 32'd9);
        check("step_busy", 32'(busy), 32'd1);
        tick(); check("step_hold", 32'(state), 32'd6);
        step_req = 1'b1;
        tick(); step_req = 1'b0;
        check("step_fetch", 32'(state), 32'd2);
        tick(); tick(); tick(); tick();
        check("step_pause2", 32'(state), 32'd6); check("step_cnt2", 32'(instr_count), 32'd10);
        tick(); check("step_one_only", 32'(instr_count), 32'd10); check("step_hold2", 32'(state), 32'd6);
        run = 1'b0; step_req = 1'b1;
        tick(); step_req = 1'b0;
        check("pause_run_prio", 32'(state), 32'd0);

        // halt opcode
        step_mode = 1'b0; run = 1'b1; ram_data = 8'hFF;
        tick(); tick(); check("halt_ir", 32'(ir), 32'hFF);
        tick(); check("halt_state", 32'(state), 32'd7); check("halt_busy", 32'(busy), 32'd0);
        check("halt_strb", 32'(strb), 32'h00000); check("halt_count", 32'(instr_count), 32'd10);
        tick(); check("halt_stay", 32'(state), 32'd7);
        run = 1'b0;
        tick(); check("halt_exit", 32'(state), 32'd0);

        // asynchronous reset during EXEC
        run = 1'b1; ram_data = 8'h05;
        tick(); tick(); tick(); check("ar_exec_strb", 32'(strb), 32'h20000);
        #2 rst = 1'b0;
        #1;
        check("ar_state", 32'(state), 32'd0); check("ar_strb", 32'(strb), 32'h00000);
        check("ar_busy", 32'(busy), 32'd0); check("ar_ir", 32'(ir), 32'h00);
        check("ar_count", 32'(instr_count), 32'd0); check("ar_grant", 32'(ram_grant_ext), 32'd0);
        tick(); check("ar_held", 32'(state), 32'd0); check("ar_held_strb", 32'(strb), 32'h00000);
        ram_data = 8'hC1; branch_taken = 1'b0; rst = 1'b1;
        tick(); check("ar_resume", 32'(state), 32'd2);

        // counter wrap using 3-cycle branches
        repeat (255 * 3) tick();
        check("wrap_255", 32'(instr_count), 32'd255); check("wrap_state", 32'(state), 32'd2);
        repeat (3) tick();
        check("wrap_0", 32'(instr_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
